// File: rtl/lc3b_mem_responder.sv
// Wait-stated memory slave for the LC-3b memory port: a 16-bit word array with byte-enable writes.
// Optional misaligned word-write detection is enabled by defining MEM_ALIGN_CHECK_EN.
module lc3b_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [1:0]  dbg_state,
  output logic        mem_resp,
  output logic [15:0] mem_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        mem_misaligned
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

  // Handshake: the master holds mem_read/mem_write until it sees the one-cycle
  // mem_resp pulse and drops them on the edge that ends it; a request is only
  // accepted in IDLE, so a request still high during RESP is never re-served.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;
  logic                    op_wr_q, op_wr_d;
  logic                    resp_q, resp_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    mem_we;
  logic                    misaligned;

  logic [15:0] mem_array [DEPTH];

`ifdef MEM_ALIGN_CHECK_EN
  logic lsb_q, lsb_d;
  logic mis_q, mis_d;

  assign misaligned     = op_wr_q && (be_q == 2'b11) && lsb_q;
  assign mem_misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits alias onto the array; bit 0 only matters for the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[15:ADDR_WIDTH+1], mem_address[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    op_wr_d = op_wr_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    lsb_d   = lsb_q;
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_address[ADDR_WIDTH:1];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          op_wr_d = mem_write;
          cnt_d   = WAIT_LOAD;
          state_d = BUSY;
`ifdef MEM_ALIGN_CHECK_EN
          lsb_d   = mem_address[0];
`endif
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = RESP;
          resp_d  = 1'b1;
          // A simultaneous read+write was latched as a write, so rdata is left alone.
          if (op_wr_q) begin
            mem_we = !misaligned;
          end else begin
            rdata_d = mem_array[idx_q];
          end
`ifdef MEM_ALIGN_CHECK_EN
          mis_d = misaligned;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      op_wr_q <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      op_wr_q <= op_wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lsb_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      lsb_q <= lsb_d;
      mis_q <= mis_d;
    end
  end
`endif

  // Array is never cleared; a reset landing on the write edge aborts the write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      if (be_q[0]) mem_array[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_array[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: a word-array model predicts every output on every cycle.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misaligned-write port.
module tb_lc3b_mem_responder;

  localparam int AW = 10;
  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [1:0]  dbg_state;
  logic        mem_resp;
  logic [15:0] mem_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_misaligned;
`endif

  lc3b_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .dbg_state       (dbg_state),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_misaligned  (mem_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Model state: word array plus the single outstanding transaction.
  logic [15:0] model_mem [0:(1<<AW)-1];
  int          resp_at = -1;
  logic        p_wr;
  int          p_idx;
  logic [15:0] p_d;
  logic [1:0]  p_be;
  logic        p_lsb;
  logic [15:0] exp_rdata = 16'h0000;
  logic        exp_resp;
  logic        exp_mis;
  logic        wr_ok;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_resp = (cyc == resp_at);
      exp_mis  = 1'b0;
      if (exp_resp) begin
        if (p_wr) begin
          wr_ok = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          if (p_be == 2'b11 && p_lsb) begin
            wr_ok   = 1'b0;
            exp_mis = 1'b1;
          end
`endif
          if (wr_ok && p_be[0]) model_mem[p_idx][7:0]  = p_d[7:0];
          if (wr_ok && p_be[1]) model_mem[p_idx][15:8] = p_d[15:8];
        end else begin
          exp_rdata = model_mem[p_idx];
        end
      end
      chk("mem_resp", {15'd0, mem_resp}, {15'd0, exp_resp});
      chk("mem_rdata", mem_rdata, exp_rdata);
`ifdef MEM_ALIGN_CHECK_EN
      chk("mem_misaligned", {15'd0, mem_misaligned}, {15'd0, exp_mis});
`endif
    end
  end

  task automatic schedule(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, input int c0);
    p_wr    = wr;
    p_idx   = int'(a[AW:1]);
    p_d     = d;
    p_be    = be;
    p_lsb   = a[0];
    resp_at = c0 + WC + 2;
  endtask

  // drop_after = 0: hold until mem_resp; otherwise drop the request after that many cycles.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] be, input int drop_after,
                     output int lat, output logic [15:0] rdv);
    int  c0;
    bit  got;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = be;
    c0 = cyc;
    schedule(wr, a, d, be, c0);
    got = 1'b0; lat = -1; rdv = 16'hxxxx;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (drop_after > 0 && (cyc - c0) >= drop_after) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
      if (mem_resp === 1'b1) begin
        got = 1'b1; lat = cyc - c0; rdv = mem_rdata;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL txn_timeout addr %h: no mem_resp within 300 cycles", a);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  int          lat;
  logic [15:0] rv;
  int          extra;
  int          c0;

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 16'h0; mem_wdata = 16'h0; mem_byte_enable = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_resp", {15'd0, mem_resp}, 16'h0000);
    chk("reset_rdata", mem_rdata, 16'h0000);
    chk_en = 1'b1;
    repeat (4) @(posedge clk);

    // Word write then readback with latency check.
    txn(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 0, lat, rv);
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, lat, rv);
    chk("read_latency", 16'(lat), 16'd5);
    chk("readback_0010", rv, 16'h1234);

    // Request held through RESP must not be re-served.
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) extra++;
    end
    chk("no_double_resp", 16'(extra), 16'd0);

    // Byte enables.
    txn(1'b0, 1'b1, 16'h0020, 16'hAAAA, 2'b11, 0, lat, rv);
    txn(1'b0, 1'b1, 16'h0020, 16'h5555, 2'b01, 0, lat, rv);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 0, lat, rv);
    chk("be01_readback", rv, 16'hAA55);
    txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b10, 0, lat, rv);
    txn(1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 0, lat, rv);
    chk("be10_readback", rv, 16'h1255);
    txn(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 0, lat, rv);
    chk("be00_latency", 16'(lat), 16'd5);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 0, lat, rv);
    chk("be00_readback", rv, 16'h1255);

    // Read dropped after one cycle still completes.
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1, lat, rv);
    chk("drop_latency", 16'(lat), 16'd5);
    chk("drop_rdata", rv, 16'h1234);

    // Read+write together acts as a write; rdata keeps the last read value.
    txn(1'b1, 1'b1, 16'h0040, 16'h7777, 2'b11, 0, lat, rv);
    chk("rdwr_rdata_held", rv, 16'h1234);
    txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 0, lat, rv);
    chk("rdwr_readback", rv, 16'h7777);

    // Reset in cycle 2 of a write aborts it.
    txn(1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, 0, lat, rv);
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hBEEF; mem_byte_enable = 2'b11;
    c0 = cyc;
    schedule(1'b1, 16'h0030, 16'hBEEF, 2'b11, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    resp_at = -1; exp_rdata = 16'h0000;
    rst_n = 1'b1;
    chk("midreset_rdata", mem_rdata, 16'h0000);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) extra++;
    end
    chk("midreset_no_resp", 16'(extra), 16'd0);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 0, lat, rv);
    chk("midreset_readback", rv, 16'h0000);

    // Address aliasing above ADDR_WIDTH.
    txn(1'b0, 1'b1, 16'h0802, 16'h0F0F, 2'b11, 0, lat, rv);
    txn(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 0, lat, rv);
    chk("wrap_readback", rv, 16'h0F0F);

    // Odd-address word write: suppressed with the check, lands on the word otherwise.
    txn(1'b0, 1'b1, 16'h0003, 16'hC3C3, 2'b11, 0, lat, rv);
    txn(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 0, lat, rv);
`ifdef MEM_ALIGN_CHECK_EN
    chk("odd_word_write", rv, 16'h0F0F);
`else
    chk("odd_word_write", rv, 16'hC3C3);
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
